axi4lite_reg_slave: RTL and testbench

AXI4LITE_REG_SLAVE -- requirements
Module: axi4lite_reg_slave

---
 rtl/axi4lite_pkg.sv | 31 +++
 rtl/axi4lite_regfile.sv | 37 +++
 rtl/axi4lite_reg_slave.sv | 172 +++++++++++++++++
 tb/tb_axi4lite_reg_slave.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// write/read FSM state encodings and the byte-strobe merge helper.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] wstate_t;
    localparam wstate_t W_IDLE      = 2'd0;
    localparam wstate_t W_HAVE_ADDR = 2'd1;
    localparam wstate_t W_HAVE_DATA = 2'd2;
    localparam wstate_t W_RESP      = 2'd3;

    typedef logic [0:0] rstate_t;
    localparam rstate_t R_IDLE = 1'b0;
    localparam rstate_t R_RESP = 1'b1;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4lite_regfile.sv
// Register array with byte-strobe write merge and combinational read mux.
// Ports: i_clk/i_rst_n, write port (i_we, i_widx, i_wdata, i_wstrb),
// read index i_ridx -> o_rdata, flat contents o_regs.
module axi4lite_regfile
    import axi4lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDXW     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_we,
    input  logic [IDXW-1:0]        i_widx,
    input  logic [31:0]            i_wdata,
    input  logic [3:0]             i_wstrb,
    input  logic [IDXW-1:0]        i_ridx,
    output logic [31:0]            o_rdata,
    output logic [NUM_REGS*32-1:0] o_regs
);

    logic [31:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_widx] <= strb_merge(r_regs[i_widx], i_wdata, i_wstrb);
        end
    end

    assign o_rdata = r_regs[i_ridx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs[32*g +: 32] = r_regs[g];
    end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; independent write
// (AW/W/B) and read (AR/R) handshake FSMs around axi4lite_regfile.
// Ports: ACLK/ARESETn, AXI4-Lite AW/W/B/AR/R channels, regs_o flat
// register contents, wr_pulse_o per-register commit pulse.
// Build option AXI4LITE_REG_SLAVE_PROT_CHECK_EN: reject AxPROT[0]=0.
module axi4lite_reg_slave
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [DATA_WIDTH-1:0]    WDATA,
    input  logic [DATA_WIDTH/8-1:0]  WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    input  logic [2:0]               ARPROT,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [DATA_WIDTH-1:0]    RDATA,
    output logic [1:0]               RRESP,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int IDXW = $clog2(NUM_REGS);

    wstate_t               r_wstate;
    rstate_t               r_rstate;
    logic                  r_live;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [2:0]            r_awprot;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [1:0]            r_bresp;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_werr;
    logic                  w_rerr;
    logic                  w_we;
    logic [IDXW-1:0]       w_widx;
    logic [IDXW-1:0]       w_ridx;
    logic [31:0]           w_rf_rdata;
    logic [NUM_REGS-1:0]   w_onehot;

    // r_live holds the ready outputs low until the first edge after reset.
    assign AWREADY = r_live && !r_pend &&
                     (r_wstate == W_IDLE || r_wstate == W_HAVE_DATA);
    assign WREADY  = r_live && !r_pend &&
                     (r_wstate == W_IDLE || r_wstate == W_HAVE_ADDR);
    assign ARREADY = r_live && (r_rstate == R_IDLE);
    assign BVALID  = (r_wstate == W_RESP);
    assign RVALID  = (r_rstate == R_RESP);
    assign BRESP   = r_bresp;
    assign RRESP   = r_rresp;
    assign RDATA   = r_rdata;

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID && WREADY;
    assign w_ar_hs = ARVALID && ARREADY;

    assign w_widx = r_awaddr[2 +: IDXW];
    assign w_ridx = ARADDR[2 +: IDXW];

`ifdef AXI4LITE_REG_SLAVE_PROT_CHECK_EN
    assign w_werr = (|(r_awaddr >> (IDXW + 2))) || !r_awprot[0];
    assign w_rerr = (|(ARADDR >> (IDXW + 2))) || !ARPROT[0];
`else
    logic w_unused;
    assign w_unused = ^{r_awprot, ARPROT};
    assign w_werr = |(r_awaddr >> (IDXW + 2));
    assign w_rerr = |(ARADDR >> (IDXW + 2));
`endif

    // r_pend marks "address and data both latched": commit on this edge.
    assign w_we       = r_pend && !w_werr;
    assign w_onehot   = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_widx;
    assign wr_pulse_o = w_we ? w_onehot : '0;

    axi4lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDXW     (IDXW)
    ) u_regfile (
        .i_clk   (ACLK),
        .i_rst_n (ARESETn),
        .i_we    (w_we),
        .i_widx  (w_widx),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_ridx  (w_ridx),
        .o_rdata (w_rf_rdata),
        .o_regs  (regs_o)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_live   <= 1'b0;
            r_wstate <= W_IDLE;
            r_pend   <= 1'b0;
            r_awaddr <= '0;
            r_awprot <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_live <= 1'b1;
            if (w_aw_hs) begin
                r_awaddr <= AWADDR;
                r_awprot <= AWPROT;
            end
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
            if (r_pend) begin
                r_pend   <= 1'b0;
                r_wstate <= W_RESP;
                r_bresp  <= w_werr ? RESP_SLVERR : RESP_OKAY;
            end else begin
                unique case (r_wstate)
                    W_IDLE: begin
                        if (w_aw_hs && w_w_hs) r_pend <= 1'b1;
                        else if (w_aw_hs)      r_wstate <= W_HAVE_ADDR;
                        else if (w_w_hs)       r_wstate <= W_HAVE_DATA;
                    end
                    W_HAVE_ADDR: if (w_w_hs)  r_pend <= 1'b1;
                    W_HAVE_DATA: if (w_aw_hs) r_pend <= 1'b1;
                    W_RESP: begin
                        if (BREADY) begin
                            r_wstate <= W_IDLE;
                            r_bresp  <= RESP_OKAY;
                        end
                    end
                    default: r_wstate <= W_IDLE;
                endcase
            end
        end
    end

    // Read data is sampled from the regfile before any same-edge commit.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rstate <= R_RESP;
            r_rdata  <= w_rerr ? '0 : w_rf_rdata;
            r_rresp  <= w_rerr ? RESP_SLVERR : RESP_OKAY;
        end else if (r_rstate == R_RESP && RREADY) begin
            r_rstate <= R_IDLE;
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed self-checking bench for axi4lite_reg_slave.
// Each task drives one scenario and checks against hand-computed values.
module tb_axi4lite_reg_slave;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  AWADDR = '0;
    logic [2:0]   AWPROT = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [1:0]   BRESP;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  ARADDR = '0;
    logic [2:0]   ARPROT = '0;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic [511:0] regs_o;
    logic [15:0]  wr_pulse_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_regs [16];

    always #5 ACLK = ~ACLK;

    axi4lite_reg_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .AWADDR     (AWADDR),
        .AWPROT     (AWPROT),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .WDATA      (WDATA),
        .WSTRB      (WSTRB),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .BRESP      (BRESP),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .ARADDR     (ARADDR),
        .ARPROT     (ARPROT),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    function automatic logic [511:0] flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[32*i +: 32] = exp_regs[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(
        input  logic [31:0] addr,
        input  logic [31:0] data,
        input  logic [3:0]  strb,
        input  logic [2:0]  prot,
        output logic [1:0]  resp
    );
        bit aw_f, w_f, b_f, done;
        int n;
        done = 0;
        n = 0;
        resp = 2'b11;
        AWADDR = addr;
        AWPROT = prot;
        WDATA = data;
        WSTRB = strb;
        AWVALID = 1'b1;
        WVALID = 1'b1;
        BREADY = 1'b1;
        while (!done && n < 50) begin
            aw_f = AWVALID && AWREADY;
            w_f = WVALID && WREADY;
            b_f = BVALID && BREADY;
            if (b_f) resp = BRESP;
            tick();
            if (aw_f) AWVALID = 1'b0;
            if (w_f) WVALID = 1'b0;
            if (b_f) done = 1;
            n++;
        end
        AWVALID = 1'b0;
        WVALID = 1'b0;
        BREADY = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL write_timeout addr=%h got no B response, required one", addr);
        end
    endtask

    task automatic axi_read(
        input  logic [31:0] addr,
        input  logic [2:0]  prot,
        output logic [31:0] data,
        output logic [1:0]  resp
    );
        bit ar_f, r_f, done;
        int n;
        done = 0;
        n = 0;
        data = 32'hxxxxxxxx;
        resp = 2'b11;
        ARADDR = addr;
        ARPROT = prot;
        ARVALID = 1'b1;
        RREADY = 1'b1;
        while (!done && n < 50) begin
            ar_f = ARVALID && ARREADY;
            r_f = RVALID && RREADY;
            if (r_f) begin
                data = RDATA;
                resp = RRESP;
            end
            tick();
            if (ar_f) ARVALID = 1'b0;
            if (r_f) done = 1;
            n++;
        end
        ARVALID = 1'b0;
        RREADY = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL read_timeout addr=%h got no R response, required one", addr);
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        tick();
        tick();
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            errors++;
            $display("FAIL rst_hs got %b required 00000",
                     {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        checks++;
        if ({BRESP, RRESP, RDATA, wr_pulse_o} !== '0) begin
            errors++;
            $display("FAIL rst_out got bresp=%b rresp=%b rdata=%h pulse=%h required 0",
                     BRESP, RRESP, RDATA, wr_pulse_o);
        end
        checks++;
        if (regs_o !== flat()) begin
            errors++;
            $display("FAIL rst_regs got %h required 0", regs_o);
        end
        ARESETn = 1'b1;
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            errors++;
            $display("FAIL rst_early_ready got %b required 000",
                     {AWREADY, WREADY, ARREADY});
        end
        tick();
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL rst_ready_rise got %b required 111",
                     {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_same_cycle();
        AWADDR = 32'h08;
        AWPROT = 3'b001;
        WDATA = 32'hDEADBEEF;
        WSTRB = 4'hF;
        AWVALID = 1'b1;
        WVALID = 1'b1;
        BREADY = 1'b0;
        tick();
        AWVALID = 1'b0;
        WVALID = 1'b0;
        checks++;
        if (wr_pulse_o !== 16'h0004 || BVALID !== 1'b0) begin
            errors++;
            $display("FAIL same_pulse got pulse=%h bvalid=%b required 0004 0",
                     wr_pulse_o, BVALID);
        end
        tick();
        exp_regs[2] = 32'hDEADBEEF;
        checks++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            errors++;
            $display("FAIL same_b got bvalid=%b bresp=%b required 1 00",
                     BVALID, BRESP);
        end
        checks++;
        if (regs_o[95:64] !== 32'hDEADBEEF || wr_pulse_o !== 16'h0) begin
            errors++;
            $display("FAIL same_reg got reg2=%h pulse=%h required deadbeef 0000",
                     regs_o[95:64], wr_pulse_o);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        checks++;
        if (BVALID !== 1'b0) begin
            errors++;
            $display("FAIL same_bdone got bvalid=%b required 0", BVALID);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r;
        axi_write(32'h04, 32'hAABBCCDD, 4'hF, 3'b001, r);
        exp_regs[1] = 32'hAABBCCDD;
        WDATA = 32'h11223344;
        WSTRB = 4'h5;
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (BVALID !== 1'b0) begin
                errors++;
                $display("FAIL wfirst_early_b cycle %0d got bvalid=%b required 0",
                         i, BVALID);
            end
            if (i < 2) tick();
        end
        AWADDR = 32'h04;
        AWPROT = 3'b001;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        tick();
        exp_regs[1] = 32'hAA22CC44;
        checks++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            errors++;
            $display("FAIL wfirst_b got bvalid=%b bresp=%b required 1 00",
                     BVALID, BRESP);
        end
        checks++;
        if (regs_o[63:32] !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL wfirst_merge got %h required aa22cc44", regs_o[63:32]);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(32'h40, 3'b001, d, r);
        checks++;
        if (r !== 2'b10 || d !== 32'h0) begin
            errors++;
            $display("FAIL oor_read got rresp=%b rdata=%h required 10 0", r, d);
        end
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 3'b001, r);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL oor_bresp got %b required 10", r);
        end
        checks++;
        if (regs_o !== flat()) begin
            errors++;
            $display("FAIL oor_regs got %h required %h", regs_o, flat());
        end
    endtask

    task automatic test_rready_stall();
        ARADDR = 32'h08;
        ARPROT = 3'b001;
        ARVALID = 1'b1;
        RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF || ARREADY !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle %0d got rvalid=%b rdata=%h arready=%b required 1 deadbeef 0",
                         i, RVALID, RDATA, ARREADY);
            end
            tick();
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got arready=%b rvalid=%b required 1 0",
                     ARREADY, RVALID);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h10, 32'hCAFEF00D, 4'hF, 3'b001, r);
        exp_regs[4] = 32'hCAFEF00D;
        axi_write(32'h14, 32'h01020304, 4'hF, 3'b001, r);
        exp_regs[5] = 32'h01020304;
        axi_write(32'h10, 32'hFFFFFFFF, 4'h0, 3'b001, r);
        checks++;
        if (r !== 2'b00) begin
            errors++;
            $display("FAIL strb0_bresp got %b required 00", r);
        end
        axi_read(32'h10, 3'b001, d, r);
        checks++;
        if (d !== 32'hCAFEF00D || r !== 2'b00) begin
            errors++;
            $display("FAIL strb0_read got %h %b required cafef00d 00", d, r);
        end
        axi_read(32'h17, 3'b001, d, r);
        checks++;
        if (d !== 32'h01020304 || r !== 2'b00) begin
            errors++;
            $display("FAIL lowbits_read got %h %b required 01020304 00", d, r);
        end
        checks++;
        if (regs_o !== flat()) begin
            errors++;
            $display("FAIL b2b_regs got %h required %h", regs_o, flat());
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] r;
        axi_write(32'h00, 32'h00001111, 4'hF, 3'b001, r);
        exp_regs[0] = 32'h00001111;
        AWADDR = 32'h00;
        AWPROT = 3'b001;
        WDATA = 32'h22222222;
        WSTRB = 4'hF;
        AWVALID = 1'b1;
        WVALID = 1'b1;
        BREADY = 1'b0;
        tick();
        AWVALID = 1'b0;
        WVALID = 1'b0;
        checks++;
        if (wr_pulse_o !== 16'h0001) begin
            errors++;
            $display("FAIL conc_pulse got %h required 0001", wr_pulse_o);
        end
        ARADDR = 32'h00;
        ARPROT = 3'b001;
        ARVALID = 1'b1;
        RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        exp_regs[0] = 32'h22222222;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'h00001111) begin
            errors++;
            $display("FAIL conc_read got rvalid=%b rdata=%h required 1 00001111",
                     RVALID, RDATA);
        end
        checks++;
        if (BVALID !== 1'b1 || regs_o[31:0] !== 32'h22222222) begin
            errors++;
            $display("FAIL conc_write got bvalid=%b reg0=%h required 1 22222222",
                     BVALID, regs_o[31:0]);
        end
        BREADY = 1'b1;
        RREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        RREADY = 1'b0;
    endtask

    task automatic test_prot();
        logic [31:0] d;
        logic [1:0]  r;
`ifdef AXI4LITE_REG_SLAVE_PROT_CHECK_EN
        axi_write(32'h18, 32'h00000055, 4'hF, 3'b000, r);
        checks++;
        if (r !== 2'b10 || regs_o !== flat()) begin
            errors++;
            $display("FAIL prot0_write got bresp=%b reg6=%h required 10 0",
                     r, regs_o[223:192]);
        end
        axi_read(32'h08, 3'b000, d, r);
        checks++;
        if (r !== 2'b10 || d !== 32'h0) begin
            errors++;
            $display("FAIL prot0_read got %b %h required 10 0", r, d);
        end
`else
        axi_read(32'h08, 3'b000, d, r);
        checks++;
        if (r !== 2'b00 || d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL prot_ign_read got %b %h required 00 deadbeef", r, d);
        end
`endif
        axi_write(32'h18, 32'h00000066, 4'hF, 3'b001, r);
        exp_regs[6] = 32'h00000066;
        checks++;
        if (r !== 2'b00 || regs_o !== flat()) begin
            errors++;
            $display("FAIL prot1_write got bresp=%b reg6=%h required 00 66",
                     r, regs_o[223:192]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        AWADDR = 32'h0C;
        AWPROT = 3'b001;
        WDATA = 32'h12345678;
        WSTRB = 4'hF;
        AWVALID = 1'b1;
        WVALID = 1'b1;
        BREADY = 1'b0;
        tick();
        AWVALID = 1'b0;
        WVALID = 1'b0;
        tick();
        checks++;
        if (BVALID !== 1'b1) begin
            errors++;
            $display("FAIL mid_pending got bvalid=%b required 1", BVALID);
        end
        #2;
        ARESETn = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        checks++;
        if (BVALID !== 1'b0 || regs_o !== flat() || wr_pulse_o !== 16'h0) begin
            errors++;
            $display("FAIL mid_rst got bvalid=%b regs=%h pulse=%h required 0",
                     BVALID, regs_o, wr_pulse_o);
        end
        tick();
        ARESETn = 1'b1;
        BREADY = 1'b1;
        tick();
        checks++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL mid_after got bvalid=%b awready=%b required 0 1",
                     BVALID, AWREADY);
        end
        BREADY = 1'b0;
        axi_read(32'h0C, 3'b001, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++;
            $display("FAIL mid_readback got %h %b required 0 00", d, r);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_out_of_range();
        test_rready_stall();
        test_back_to_back();
        test_concurrent();
        test_prot();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
